// File: rtl/counter_cmd_ctrl.sv
// ============================================================================
// Module      : counter_cmd_ctrl
// Description : Command sequencer that drives an up/down counter's control
//               pins from LOAD / COUNT_UP / COUNT_DOWN / HOLD host commands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cmd_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              cmd_stop_lim,
    output logic              load_n,
    output logic              ce,
    output logic              up_down,
    output logic [WIDTH-1:0]  data_load,
    input  logic [WIDTH-1:0]  count_out,
    input  logic              zero,
    input  logic              max_count,
    output logic              busy,
    output logic              done,
    output logic              hit_limit,
    output logic [STEP_W-1:0] steps_done
);

    localparam logic [1:0] c_OP_LOAD = 2'b00;
    localparam logic [1:0] c_OP_UP   = 2'b01;
    localparam logic [1:0] c_OP_DOWN = 2'b10;
    localparam logic [1:0] c_OP_HOLD = 2'b11;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    localparam logic [STEP_W-1:0] c_ONE = STEP_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_up_down;
    logic              r_stop_lim;
    logic              r_hit;
    logic [WIDTH-1:0]  r_data_load;
    logic [STEP_W-1:0] r_remaining;
    logic [STEP_W-1:0] r_steps;
    logic              w_accept;
    logic              w_limit;
    logic              w_unused;

    // The counter value itself is not needed; limits arrive as zero/max_count.
    assign w_unused = ^count_out;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_limit  = r_stop_lim && (r_up_down ? max_count : zero);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == c_OP_LOAD) begin
                        w_state_nxt = c_S_LOAD;
                    end else if ((cmd_op == c_OP_HOLD) || (cmd_arg == '0)) begin
                        w_state_nxt = c_S_DONE;
                    end else begin
                        w_state_nxt = c_S_RUN;
                    end
                end
            end
            c_S_LOAD: w_state_nxt = c_S_DONE;
            c_S_RUN: begin
                if (w_limit || (r_remaining == c_ONE)) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_up_down   <= 1'b0;
            r_stop_lim  <= 1'b0;
            r_hit       <= 1'b0;
            r_data_load <= '0;
            r_remaining <= '0;
            r_steps     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_steps     <= '0;
                        r_hit       <= 1'b0;
                        r_remaining <= cmd_arg;
                        r_stop_lim  <= cmd_stop_lim;
                        if (cmd_op == c_OP_LOAD) begin
                            r_data_load <= cmd_arg[WIDTH-1:0];
                        end
                        // Direction only changes on a count command; it holds otherwise.
                        if (cmd_op == c_OP_UP) begin
                            r_up_down <= 1'b1;
                        end else if (cmd_op == c_OP_DOWN) begin
                            r_up_down <= 1'b0;
                        end
                    end
                end
                c_S_RUN: begin
                    if (w_limit) begin
                        r_hit <= 1'b1;
                    end else begin
                        r_steps     <= r_steps + c_ONE;
                        r_remaining <= r_remaining - c_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pins are gated by rst_n so a reset mid-command silences the counter at once.
    assign cmd_ready  = rst_n && (r_state == c_S_IDLE);
    assign load_n     = !(rst_n && (r_state == c_S_LOAD));
    assign ce         = rst_n && (r_state == c_S_RUN) && !w_limit;
    assign up_down    = r_up_down;
    assign data_load  = r_data_load;
    assign busy       = (r_state != c_S_IDLE);
    assign done       = (r_state == c_S_DONE);
    assign hit_limit  = done && r_hit;
    assign steps_done = r_steps;

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_ctrl.sv
// ============================================================================
// Module      : tb_counter_cmd_ctrl
// Description : Self-checking bench for counter_cmd_ctrl with an attached
//               behavioural up/down counter and an arithmetic command model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_cmd_ctrl;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [STEP_W-1:0] cmd_arg = '0;
    logic              cmd_stop_lim = 1'b0;
    logic              load_n;
    logic              ce;
    logic              up_down;
    logic [WIDTH-1:0]  data_load;
    logic [WIDTH-1:0]  count_out;
    logic              zero;
    logic              max_count;
    logic              busy;
    logic              done;
    logic              hit_limit;
    logic [STEP_W-1:0] steps_done;

    logic [WIDTH-1:0]  cnt = '0;
    int                n_assert = 0;
    int                n_fail = 0;
    int                m_cnt = 0;

    counter_cmd_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .cmd_stop_lim(cmd_stop_lim),
        .load_n(load_n), .ce(ce), .up_down(up_down), .data_load(data_load),
        .count_out(count_out), .zero(zero), .max_count(max_count),
        .busy(busy), .done(done), .hit_limit(hit_limit), .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    // Shared counter the controller drives
    always @(posedge clk) begin
        if (!load_n)  cnt <= data_load;
        else if (ce)  cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign count_out = cnt;
    assign zero      = (cnt == 4'h0);
    assign max_count = (cnt == 4'hF);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command, predict its outcome arithmetically and check every cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input logic stop);
        int  exp_steps, exp_hit, exp_lat, room, k, lat;
        int  ce_n, ld_n, ld_first, bad_dir, overlap, not_busy;
        int  obs_steps, obs_hit, obs_cnt;
        logic [3:0] ld_val;
        bit  got;
        exp_steps = 0; exp_hit = 0; exp_lat = 1;
        if (op == 2'd0) begin
            exp_lat = 2;
            m_cnt   = int'(arg) % 16;
        end else if ((op == 2'd1 || op == 2'd2) && arg != 0) begin
            room = (op == 2'd1) ? 15 - m_cnt : m_cnt;
            if (stop && room < int'(arg)) begin
                exp_steps = room; exp_hit = 1; exp_lat = room + 2;
            end else begin
                exp_steps = int'(arg); exp_lat = int'(arg) + 1;
            end
            m_cnt = (op == 2'd1) ? (m_cnt + exp_steps) % 16 : (m_cnt - exp_steps + 32) % 16;
        end
        @(negedge clk);
        cmd_op = op; cmd_arg = arg; cmd_stop_lim = stop; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        ce_n = 0; ld_n = 0; ld_first = 0; bad_dir = 0; overlap = 0; not_busy = 0;
        obs_steps = 0; obs_hit = 0; obs_cnt = 0; lat = 0; ld_val = '0; got = 1'b0;
        for (int c = 1; c <= 300 && !got; c++) begin
            @(negedge clk);
            if (!busy) not_busy++;
            if (ce) begin
                ce_n++;
                if (up_down !== (op == 2'd1)) bad_dir++;
            end
            if (!load_n) begin
                ld_n++;
                if (ld_first == 0) begin ld_first = c; ld_val = data_load; end
            end
            if (!load_n && ce) overlap++;
            if (done) begin
                got = 1'b1; lat = c;
                obs_steps = int'(steps_done); obs_hit = int'(hit_limit); obs_cnt = int'(count_out);
            end
        end
        check("done_seen", 32'(got), 1);
        check("done_latency", lat, exp_lat);
        check("ce_cycles", ce_n, exp_steps);
        check("steps_done", obs_steps, exp_steps);
        check("hit_limit", obs_hit, exp_hit);
        check("count_at_done", obs_cnt, m_cnt);
        check("load_cycles", ld_n, (op == 2'd0) ? 1 : 0);
        check("ce_direction", bad_dir, 0);
        check("load_ce_overlap", overlap, 0);
        check("busy_in_cmd", not_busy, 0);
        if (op == 2'd0) begin
            check("load_cycle_pos", ld_first, 1);
            check("load_value", 32'(ld_val), 32'(arg[3:0]));
        end
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 1);
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic wait_done(output int ce_n, output int not_busy, output bit got);
        ce_n = 0; not_busy = 0; got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (ce) ce_n++;
            if (!busy) not_busy++;
            if (done) got = 1'b1;
        end
    endtask

    initial begin
        int  ce_n, nb, dones;
        bit  got;
        logic [1:0] rop;

        // Reset held with a command offered
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(cmd_ready), 0);
            check("rst_load_n", 32'(load_n), 1);
            check("rst_ce", 32'(ce), 0);
            check("rst_done", 32'(done), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_steps", 32'(steps_done), 0);
            check("rst_data_load", 32'(data_load), 0);
        end
        rst_n = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_count", 32'(count_out), 0);

        // Directed: load, wrap, limit stops, hold
        run_cmd(2'd0, 8'h0A, 1'b0);
        run_cmd(2'd0, 8'h0D, 1'b0);
        run_cmd(2'd1, 8'd3, 1'b0);
        run_cmd(2'd0, 8'h0D, 1'b0);
        run_cmd(2'd1, 8'd5, 1'b1);
        run_cmd(2'd0, 8'h00, 1'b0);
        run_cmd(2'd2, 8'd4, 1'b1);
        run_cmd(2'd3, 8'd7, 1'b0);
        run_cmd(2'd2, 8'd0, 1'b0);
        run_cmd(2'd2, 8'd3, 1'b0);

        // Back-to-back with cmd_valid held high
        run_cmd(2'd0, 8'h05, 1'b0);
        cmd_op = 2'd1; cmd_arg = 8'd2; cmd_stop_lim = 1'b0; cmd_valid = 1'b1;
        wait_done(ce_n, nb, got);
        check("b2b_first_done", 32'(got), 1);
        check("b2b_first_ce", ce_n, 2);
        check("b2b_first_count", 32'(count_out), 7);
        check("b2b_ready_in_done", 32'(cmd_ready), 0);
        cmd_op = 2'd2;
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 0);
        check("b2b_idle_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(ce_n, nb, got);
        check("b2b_second_done", 32'(got), 1);
        check("b2b_second_busy", nb, 0);
        check("b2b_second_ce", ce_n, 2);
        check("b2b_second_steps", 32'(steps_done), 2);
        check("b2b_second_count", 32'(count_out), 5);
        m_cnt = 5;
        @(negedge clk);

        // Reset in the middle of a long count
        cmd_op = 2'd1; cmd_arg = 8'd10; cmd_stop_lim = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run_ce", 32'(ce), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ce", 32'(ce), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        dones = 0; ce_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (ce) ce_n++;
        end
        check("aborted_no_done", dones, 0);
        check("aborted_no_ce", ce_n, 0);

        // Randomized commands against the arithmetic model
        run_cmd(2'd0, 8'h07, 1'b0);
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'd0)
                run_cmd(rop, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            else
                run_cmd(rop, 8'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
